arb2_mux: RTL and testbench

// Upstream control stage for the 2:1 mux datapath. Takes two valid/ready

---
 rtl/arb2_mux.sv | 88 ++++++++
 tb/tb_arb2_mux.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/arb2_mux.sv
// Round-robin arbiter for two valid/ready sources feeding a one-entry output slice.
// Drives the mux select combinationally and keeps saturating per-source grant counts.
module arb2_mux #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic             sel,
  output logic [WIDTH-1:0] f_data,
  output logic             f_valid,
  input  logic             f_ready,
  output logic             f_src,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t state;
  logic   last;
  logic   grant;
  logic   space;
  logic   load;

  assign f_valid = (state == FULL);
  assign space   = ~f_valid | f_ready;
  assign load    = space & (a_valid | b_valid);

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    grant = last;
    if (a_valid && !b_valid)      grant = 1'b0;
    else if (b_valid && !a_valid) grant = 1'b1;
    else if (a_valid && b_valid)  grant = ~last;
  end

  assign sel = grant;

  // Readies are forced low while reset is held so nothing is consumed during reset.
  assign a_ready = rst_n & space & ~grant;
  assign b_ready = rst_n & space & grant;

  // NOTE: sequential state uses non-blocking assignments and an async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      f_data <= '0;
      f_src  <= 1'b0;
      last   <= 1'b1;
      cnt_a  <= '0;
      cnt_b  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (load) state <= FULL;
        end
        FULL: begin
          if (f_ready && !load) state <= EMPTY;
        end
        default: state <= EMPTY;
      endcase

      if (load) begin
        f_data <= grant ? b_data : a_data;
        f_src  <= grant;
        last   <= grant;
        if (grant) begin
          if (cnt_b != CNT_MAX) cnt_b <= cnt_b + 1'b1;
        end else begin
          if (cnt_a != CNT_MAX) cnt_a <= cnt_a + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_arb2_mux.sv
// Self-checking bench for arb2_mux: directed scenarios plus randomized traffic
// compared each cycle against a behavioural model; a second CNT_W=2 instance checks saturation.
module tb_arb2_mux;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst_n;
  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid, f_ready;

  logic       a_ready, b_ready, sel, f_valid, f_src;
  logic [7:0] f_data, cnt_a, cnt_b;

  logic       a_ready2, b_ready2, sel2, f_valid2, f_src2;
  logic [7:0] f_data2;
  logic [1:0] cnt_a2, cnt_b2;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  bit      m_full;
  bit      m_last;
  bit      m_src;
  bit [7:0] m_data;
  int      m_cnt_a, m_cnt_b, m_cnt_a2, m_cnt_b2;

  always #5 if (clk_en) clk = ~clk;

  arb2_mux #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .sel(sel), .f_data(f_data), .f_valid(f_valid), .f_ready(f_ready),
    .f_src(f_src), .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  arb2_mux #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready2),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready2),
    .sel(sel2), .f_data(f_data2), .f_valid(f_valid2), .f_ready(f_ready),
    .f_src(f_src2), .cnt_a(cnt_a2), .cnt_b(cnt_b2)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit exp_sel();
    if (a_valid && !b_valid) return 1'b0;
    if (b_valid && !a_valid) return 1'b1;
    if (a_valid && b_valid)  return !m_last;
    return m_last;
  endfunction

  task automatic model_reset();
    m_full = 0; m_last = 1; m_src = 0; m_data = 8'h00;
    m_cnt_a = 0; m_cnt_b = 0; m_cnt_a2 = 0; m_cnt_b2 = 0;
  endtask

  // Advance the model by one clock edge using the inputs seen before it.
  task automatic model_edge();
    bit space, g;
    space = !m_full || f_ready;
    if (space && (a_valid || b_valid)) begin
      g = exp_sel();
      m_data = g ? b_data : a_data;
      m_src  = g;
      m_last = g;
      m_full = 1;
      if (g) begin
        if (m_cnt_b < 255) m_cnt_b++;
        if (m_cnt_b2 < 3)  m_cnt_b2++;
      end else begin
        if (m_cnt_a < 255) m_cnt_a++;
        if (m_cnt_a2 < 3)  m_cnt_a2++;
      end
    end else if (m_full && f_ready) begin
      m_full = 0;
    end
  endtask

  task automatic compare_all();
    bit space, g;
    space = !m_full || f_ready;
    g = exp_sel();
    check("sel",     sel,     g);
    check("a_ready", a_ready, space && !g);
    check("b_ready", b_ready, space && g);
    check("f_valid", f_valid, m_full);
    check("f_data",  f_data,  m_data);
    check("f_src",   f_src,   m_src);
    check("cnt_a",   cnt_a,   m_cnt_a);
    check("cnt_b",   cnt_b,   m_cnt_b);
    check("cnt_a2",  cnt_a2,  m_cnt_a2);
    check("cnt_b2",  cnt_b2,  m_cnt_b2);
  endtask

  // Drive inputs mid-cycle, compare, then cross one rising edge.
  task automatic step(input bit av, input logic [7:0] ad, input bit bv, input logic [7:0] bd, input bit fr);
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd; f_ready = fr;
    #1;
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_f_valid", f_valid, 1'b0);
    check("rst_a_ready", a_ready, 1'b0);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int src_pat[4];
    src_pat = '{0, 1, 0, 1};

    // Reset with no clock running
    rst_n = 1'b0;
    a_valid = 1; b_valid = 1; a_data = 8'h5A; b_data = 8'h6B; f_ready = 1;
    #3;
    check("reset_f_valid", f_valid, 1'b0);
    check("reset_cnt_a",   cnt_a,   8'd0);
    check("reset_cnt_b",   cnt_b,   8'd0);
    check("reset_a_ready", a_ready, 1'b0);
    check("reset_b_ready", b_ready, 1'b0);
    model_reset();

    clk_en = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("first_tie_sel", sel, 1'b0);

    // A only
    step(1, 8'h11, 0, 8'h00, 1);
    step(1, 8'h22, 0, 8'h00, 1);
    step(1, 8'h33, 0, 8'h00, 1);
    check("aonly_f_data", f_data, 8'h33);
    check("aonly_f_src",  f_src,  1'b0);
    check("aonly_cnt_a",  cnt_a,  8'd3);

    // Both valid, alternating grants from a fresh reset
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 8'(8'h40 + i), 1, 8'(8'h80 + i), 1);
      check("rr_f_src", f_src, src_pat[i]);
    end
    check("rr_cnt_a", cnt_a, 8'd2);
    check("rr_cnt_b", cnt_b, 8'd2);

    // Backpressure
    step(1, 8'hA5, 0, 8'h00, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 8'h3C, 1, 8'hC3, 0);
      check("bp_f_data",  f_data,  8'hA5);
      check("bp_a_ready", a_ready, 1'b0);
      check("bp_b_ready", b_ready, 1'b0);
    end
    step(1, 8'h3C, 1, 8'hC3, 1);
    check("bp_release_f_data", f_data, 8'hC3);

    // Saturation on the CNT_W=2 instance
    for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 8'(8'h10 + i), 1);
    check("sat_cnt_b2", cnt_b2, 2'd3);
    step(0, 8'h00, 1, 8'h99, 1);
    check("sat_cnt_b2_hold", cnt_b2, 2'd3);

    // Async reset while the slice is full and stalled
    step(1, 8'h77, 0, 8'h00, 0);
    check("pre_rst_f_valid", f_valid, 1'b1);
    do_reset();
    a_valid = 1; b_valid = 1;
    #1;
    check("post_rst_tie_sel", sel, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 60), 8'($urandom),
           ($urandom_range(0, 99) < 60), 8'($urandom),
           ($urandom_range(0, 99) < 70));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
